// File: rtl/conv_window3x3.sv
// conv_window3x3: streaming 3x3 window generator over a raster-order padded frame.
// Two line buffers hold the previous two rows. Each accepted pixel shifts the
// column {row-2, row-1, current} into a 3x3 register window. A window is
// flagged valid only when it lies entirely inside one frame and one row.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | between frames; the next accepted pixel is taken as (0,0)
// FILL  | rows 0..1 of a frame; line buffers are filling, no windows yet
// RUN   | rows 2..IMG_H-1; a window is emitted for every pixel with col >= 2
module conv_window3x3 #(
  parameter int WIDTH = 9,
  parameter int IMG_W = 30,
  parameter int IMG_H = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  output logic [9*WIDTH-1:0] win,
  output logic               out_last,
  output logic               frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d, eff_col;
  logic [RW-1:0]     row_q, row_d, eff_row;
  logic              restart, at_eol, at_eof, win_ok;
  logic [WIDTH-1:0]  tap0, tap1;
  logic [WIDTH-1:0]  lb0 [IMG_W];
  logic [WIDTH-1:0]  lb1 [IMG_W];

  // Position of the pixel being accepted now, next counters and next FSM state.
  // An sof or the first pixel after IDLE is forced to (0,0), which is what
  // throws away any partial frame and keeps stale line data masked.
  always_comb begin
    restart = in_sof || (state_q == IDLE);
    eff_col = restart ? '0 : col_q;
    eff_row = restart ? '0 : row_q;
    at_eol  = (eff_col == CW'(IMG_W - 1));
    at_eof  = at_eol && (eff_row == RW'(IMG_H - 1));
    win_ok  = (eff_row >= RW'(2)) && (eff_col >= CW'(2));
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    if (in_valid) begin
      if (at_eol) begin
        col_d = '0;
        row_d = at_eof ? '0 : eff_row + RW'(1);
      end else begin
        col_d = eff_col + CW'(1);
        row_d = eff_row;
      end
      if (at_eof)
        state_d = IDLE;
      else if (row_d >= RW'(2))
        state_d = RUN;
      else
        state_d = FILL;
    end
  end

  assign tap1 = lb1[eff_col];
  assign tap0 = lb0[eff_col];

  // FSM state and pixel position counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Line buffers: row-1 ages into row-2, the new pixel becomes row-1. No reset needed.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1[eff_col] <= tap0;
      lb0[eff_col] <= in_data;
    end
  end

  // Window shift register and output flags. The window holds while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win        <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= in_valid && win_ok;
      out_last   <= in_valid && win_ok && at_eof;
      frame_done <= in_valid && win_ok && at_eof;
      if (in_valid) begin
        for (int r = 0; r < 3; r++) begin
          win[WIDTH*(3*r+0) +: WIDTH] <= win[WIDTH*(3*r+1) +: WIDTH];
          win[WIDTH*(3*r+1) +: WIDTH] <= win[WIDTH*(3*r+2) +: WIDTH];
        end
        win[WIDTH*2 +: WIDTH] <= tap1;
        win[WIDTH*5 +: WIDTH] <= tap0;
        win[WIDTH*8 +: WIDTH] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_conv_window3x3.sv
// tb_conv_window3x3: directed frames with pixel = base+row+col; every output
// is compared per cycle against a position model kept by the bench.
module tb_conv_window3x3;

  localparam int W  = 9;
  localparam int IW = 30;
  localparam int IH = 30;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_sof = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           out_valid;
  logic [9*W-1:0] win;
  logic           out_last;
  logic           frame_done;

  int n_chk = 0;
  int n_fail = 0;
  int er = 0, ec = 0;
  int n_win, n_last, n_fd;
  logic [9*W-1:0] first_win, last_win;
  logic [9*W-1:0] win_hist [$];

  conv_window3x3 #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .out_valid(out_valid), .win(win),
    .out_last(out_last), .frame_done(frame_done)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9*W-1:0] pack9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    logic [9*W-1:0] v;
    v = {W'(e8), W'(e7), W'(e6), W'(e5), W'(e4), W'(e3), W'(e2), W'(e1), W'(e0)};
    return v;
  endfunction

  function automatic logic [9*W-1:0] exp_win(input int base, input int rr, input int cc);
    logic [9*W-1:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[W*(3*r+c) +: W] = W'(base + (rr - 2 + r) + (cc - 2 + c));
    return v;
  endfunction

  task automatic clear_stats();
    n_win = 0; n_last = 0; n_fd = 0;
    first_win = '0; last_win = '0;
    win_hist.delete();
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    @(posedge clk); #1;
    check("idle_valid", 128'(out_valid), 128'(0));
  endtask

  // Send n pixels from the bench's current position; optional sof on the first one.
  task automatic send(input int base, input int n, input bit sof_first, input bit gap);
    bit exp_v, exp_l;
    for (int i = 0; i < n; i++) begin
      if (sof_first && i == 0) begin er = 0; ec = 0; end
      in_valid = 1'b1;
      in_sof   = sof_first && (i == 0);
      in_data  = W'(base + er + ec);
      @(posedge clk); #1;
      exp_v = (er >= 2) && (ec >= 2);
      exp_l = exp_v && (er == IH-1) && (ec == IW-1);
      check("out_valid", 128'(out_valid), 128'(exp_v));
      check("out_last", 128'(out_last), 128'(exp_l));
      check("frame_done", 128'(frame_done), 128'(exp_l));
      if (exp_v) check("win", 128'(win), 128'(exp_win(base, er, ec)));
      if (out_valid) begin
        if (n_win == 0) first_win = win;
        last_win = win;
        win_hist.push_back(win);
        n_win++;
      end
      if (out_last) n_last++;
      if (frame_done) n_fd++;
      if (ec == IW-1) begin
        ec = 0;
        er = (er == IH-1) ? 0 : er + 1;
      end else begin
        ec++;
      end
      if (gap) idle_cycle();
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  logic [9*W-1:0] ref_hist [$];

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_last", 128'(out_last), 128'(0));
    check("rst_fd", 128'(frame_done), 128'(0));
    check("rst_win", 128'(win), 128'(0));
    rst_n = 1'b1;
    idle_cycle();

    // continuous frame
    clear_stats();
    send(0, IW*IH, 1'b0, 1'b0);
    check("f1_windows", 128'(n_win), 128'(784));
    check("f1_first", 128'(first_win), 128'(pack9(0,1,2,1,2,3,2,3,4)));
    check("f1_last", 128'(last_win), 128'(pack9(54,55,56,55,56,57,56,57,58)));
    check("f1_nlast", 128'(n_last), 128'(1));
    check("f1_nfd", 128'(n_fd), 128'(1));
    ref_hist = win_hist;
    idle_cycle();

    // same frame with alternating idle cycles
    clear_stats();
    send(0, IW*IH, 1'b0, 1'b1);
    check("gap_windows", 128'(n_win), 128'(784));
    check("gap_nfd", 128'(n_fd), 128'(1));
    if (win_hist.size() == ref_hist.size())
      for (int i = 0; i < win_hist.size(); i++)
        check("gap_order", 128'(win_hist[i]), 128'(ref_hist[i]));

    // reset after 100 pixels, then a full frame
    clear_stats();
    send(0, 100, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", 128'(out_valid), 128'(0));
    check("mid_rst_win", 128'(win), 128'(0));
    rst_n = 1'b1;
    er = 0; ec = 0;
    clear_stats();
    send(0, IW*IH, 1'b0, 1'b0);
    check("rst_windows", 128'(n_win), 128'(784));
    check("rst_nfd", 128'(n_fd), 128'(1));

    // sof on pixel 50, then a 900-pixel frame
    clear_stats();
    send(0, 49, 1'b0, 1'b0);
    clear_stats();
    send(0, IW*IH, 1'b1, 1'b0);
    check("sof50_windows", 128'(n_win), 128'(784));
    check("sof50_nfd", 128'(n_fd), 128'(1));

    // sof deep in a frame: partial windows stop, no frame_done for it
    clear_stats();
    send(7, 500, 1'b0, 1'b0);
    clear_stats();
    send(0, IW*IH, 1'b1, 1'b0);
    check("sof500_windows", 128'(n_win), 128'(784));
    check("sof500_first", 128'(first_win), 128'(pack9(0,1,2,1,2,3,2,3,4)));
    check("sof500_nfd", 128'(n_fd), 128'(1));

    // two back-to-back frames
    clear_stats();
    send(0, IW*IH, 1'b0, 1'b0);
    check("b2b_f1_windows", 128'(n_win), 128'(784));
    send(100, IW*IH, 1'b0, 1'b0);
    check("b2b_windows", 128'(n_win), 128'(1568));
    check("b2b_nlast", 128'(n_last), 128'(2));
    if (win_hist.size() > 784)
      check("b2b_f2_first", 128'(win_hist[784]), 128'(pack9(100,101,102,101,102,103,102,103,104)));
    else
      check("b2b_f2_present", 128'(win_hist.size()), 128'(1568));
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window3x3.md
CONV_WINDOW3X3 -- requirements
Module: conv_window3x3

Interface
REQ-001 The block SHALL have parameter WIDTH, default 9, pixel bit width.
REQ-002 The block SHALL have parameter IMG_W, default 30, padded frame width in pixels.
REQ-003 The block SHALL have parameter IMG_H, default 30, padded frame height in pixels.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port in_valid  input  1  in_data carries a pixel this cycle.
REQ-007 The block SHALL have port in_sof  input  1  qualified by in_valid; the pixel is frame position (0,0).
REQ-008 The block SHALL have port in_data  input  WIDTH  raster-order pixel of the padded frame, row-major.
REQ-009 The block SHALL have port out_valid  output  1  win holds a complete 3x3 window.
REQ-010 The block SHALL have port win  output  9*WIDTH  window; element (r,c) at bits WIDTH*(3r+c) +: WIDTH, with r=0 the top row and c=0 the left column.
REQ-011 The block SHALL have port out_last  output  1  qualified by out_valid; last window of the frame.
REQ-012 The block SHALL have port frame_done  output  1  one-cycle pulse after the frame's final pixel is accepted.

Function
REQ-013 The block SHALL accept a pixel on every cycle with in_valid=1, with no backpressure.
REQ-014 The block SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) for the next accepted pixel.
- Each accepted pixel advances col.
- At col=IMG_W-1, col wraps to 0 and row increments.
- At (IMG_H-1, IMG_W-1), both counters wrap to 0.
REQ-015 The block SHALL store the two previous rows in two IMG_W-deep line buffers.
- Each accepted pixel shifts the column of {linebuf1, linebuf0, in_data} into a 3x3 register window.
- Idle cycles shall leave all storage unchanged.
REQ-016 The block SHALL run a 3-state FSM:
- IDLE to FILL on the first accepted pixel.
- FILL to RUN when row reaches 2.
- RUN to IDLE after pixel (IMG_H-1, IMG_W-1) is accepted.
- A pixel accepted in IDLE is treated as (0,0).
REQ-017 The block SHALL assert out_valid exactly one cycle after accepting a pixel at (R,C) with R>=2 and C>=2.
- win then holds pixels (R-2..R, C-2..C).
- This gives (IMG_H-2)*(IMG_W-2) windows per frame, 784 with the defaults.
REQ-018 out_valid SHALL be 0 on every other cycle, including cycles after in_valid=0, and no window shall straddle a row wrap.
REQ-019 out_last SHALL equal out_valid AND (window from pixel (IMG_H-1, IMG_W-1)).
REQ-020 frame_done SHALL pulse in the same cycle as that out_last.
REQ-021 When in_valid and in_sof are both 1, the pixel SHALL be taken as (0,0) regardless of counters or FSM state.
- The FSM goes to FILL.
- No window is emitted until row 2 of the new frame.
- Pending partial-frame windows are discarded.
- Any frame_done is suppressed for the aborted frame.
REQ-022 The block SHALL accept back-to-back frames with no gap cycle; the first window of a frame shall contain only that frame's pixels.
REQ-023 win SHALL hold its last value while out_valid=0, and the value of win while out_valid=0 SHALL be don't-care for checking.

Reset
REQ-024 While rst_n=0 at a clk edge, the block SHALL set:
- col and row to 0;
- FSM to IDLE;
- out_valid, out_last and frame_done to 0;
- win to 0.
REQ-025 Line buffer contents SHALL NOT require reset, since REQ-017 masks them until refilled.
REQ-026 A reset mid-frame SHALL discard the partial frame, and the next accepted pixel SHALL be (0,0).

Verification
REQ-027 Continuous 30x30 frame, pixel = row+col → first out_valid 1 cycle after the 63rd pixel with win = {0,1,2,1,2,3,2,3,4}; 784 windows; last win = {54,55,56,55,56,57,56,57,58}; out_last and frame_done together once.
REQ-028 Same frame with in_valid alternating 1/0 → identical 784 windows in the same order, with out_valid never asserted on the cycle after an idle cycle.
REQ-029 rst_n=0 for 1 cycle after 100 pixels, then a full frame → no out_valid during or after reset until the 63rd new pixel; 784 windows; frame_done once.
REQ-030 in_sof asserted on pixel 50 of a frame, then 900 pixels → no window emitted from the aborted frame after the sof, exactly 784 windows after it, frame_done once.
REQ-031 Two frames back-to-back (1800 consecutive pixels, frame 2 pixel = 100+row+col) → 1568 windows; first frame-2 window = {100,101,102,101,102,103,102,103,104}; two out_last pulses.
